ex_mem_stage: RTL and testbench

// Execute stage plus EX/MEM pipeline register. Consumes ID/EX register outputs, forwards operands,

---
 rtl/ex_mem_stage.sv | 144 ++++++++++++++
 tb/tb_ex_mem_stage.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: execute stage with operand forwarding, iterative shift-add multiplier and EX/MEM register
module ex_mem_stage #(
    parameter int WIDTH = 32,
    parameter int RA_W  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] alu_data,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic [WIDTH-1:0] sign_extend_inp,
    input  logic [RA_W-1:0]  rt_address,
    input  logic [RA_W-1:0]  rd_address,
    input  logic             regDest,
    input  logic             jump,
    input  logic             branch,
    input  logic             MemRead,
    input  logic             MemtoReg,
    input  logic             MemWrite,
    input  logic             ALUSrc,
    input  logic             RegWrite,
    input  logic [1:0]       ALUOp,
    input  logic [RA_W-1:0]  rs_address,
    input  logic             memwb_RegWrite,
    input  logic [RA_W-1:0]  memwb_rd,
    input  logic [WIDTH-1:0] memwb_data,
    input  logic             flush,
    output logic             stall_out,
    output logic [WIDTH-1:0] alu_result_out,
    output logic [WIDTH-1:0] store_data_out,
    output logic [RA_W-1:0]  write_reg_out,
    output logic [WIDTH-1:0] branch_target_out,
    output logic             zero_out,
    output logic             jump_out,
    output logic             branch_out,
    output logic             MemRead_out,
    output logic             MemtoReg_out,
    output logic             MemWrite_out,
    output logic             RegWrite_out
);
    localparam int CW = $clog2(WIDTH) + 1;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_nxt;
    logic [CW-1:0] count;
    logic [WIDTH-1:0] mcand, mplier, acc;
    logic [WIDTH-1:0] fwd_a, fwd_b, op2, alu_res;
    logic [5:0] funct;
    logic is_mul, valid_op, bubble;

    assign funct  = sign_extend_inp[5:0];
    assign is_mul = (ALUOp == 2'b10) && (funct == 6'h18);
    // EX/MEM result has priority over the older MEM/WB value
    assign fwd_a = (RegWrite_out && write_reg_out == rs_address && rs_address != '0) ? alu_result_out :
                   (memwb_RegWrite && memwb_rd == rs_address && rs_address != '0) ? memwb_data : rs;
    assign fwd_b = (RegWrite_out && write_reg_out == rt_address && rt_address != '0) ? alu_result_out :
                   (memwb_RegWrite && memwb_rd == rt_address && rt_address != '0) ? memwb_data : rt;
    assign op2    = ALUSrc ? sign_extend_inp : fwd_b;
    assign bubble = stall_out | flush;

    always_comb begin
        alu_res  = '0;
        valid_op = 1'b1;
        if (ALUOp == 2'b01) alu_res = fwd_a - op2;
        else if (ALUOp != 2'b10) alu_res = fwd_a + op2;
        else case (funct)
            6'h20: alu_res = fwd_a + op2;
            6'h22: alu_res = fwd_a - op2;
            6'h24: alu_res = fwd_a & op2;
            6'h25: alu_res = fwd_a | op2;
            6'h2A: alu_res = {{(WIDTH-1){1'b0}}, $signed(fwd_a) < $signed(op2)};
            6'h18: alu_res = acc;
            default: valid_op = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        stall_out = 1'b0;
        if (!reset) case (state)
            IDLE: if (is_mul && !flush) begin
                stall_out = 1'b1;
                state_nxt = BUSY;
            end
            BUSY: if (flush) state_nxt = IDLE;
            else begin
                stall_out = 1'b1;
                if (count == CW'(WIDTH - 1)) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk)
        if (reset) state <= IDLE;
        else state <= state_nxt;

    // operands track the forwarded values while idle so the start edge latches them
    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (state == IDLE) begin
            count  <= '0;
            acc    <= '0;
            mcand  <= fwd_a;
            mplier <= fwd_b;
        end else if (state == BUSY) begin
            count  <= count + 1'b1;
            acc    <= mplier[0] ? acc + mcand : acc;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            alu_result_out    <= '0;
            store_data_out    <= '0;
            write_reg_out     <= '0;
            branch_target_out <= '0;
            zero_out          <= 1'b0;
            jump_out          <= 1'b0;
            branch_out        <= 1'b0;
            MemRead_out       <= 1'b0;
            MemtoReg_out      <= 1'b0;
            MemWrite_out      <= 1'b0;
            RegWrite_out      <= 1'b0;
        end else begin
            alu_result_out    <= alu_res;
            store_data_out    <= fwd_b;
            write_reg_out     <= regDest ? rd_address : rt_address;
            branch_target_out <= alu_data + (sign_extend_inp << 2);
            zero_out          <= alu_res == '0;
            jump_out          <= jump & ~bubble;
            branch_out        <= branch & ~bubble;
            MemRead_out       <= MemRead & ~bubble;
            MemtoReg_out      <= MemtoReg & ~bubble;
            MemWrite_out      <= MemWrite & ~bubble;
            RegWrite_out      <= RegWrite & valid_op & ~bubble;
        end
    end
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed vector table plus hand-written multiply, flush and reset sequences
module tb_ex_mem_stage;
    logic clk = 1'b0, reset;
    logic [31:0] alu_data, rs, rt, sign_extend_inp, memwb_data;
    logic [4:0] rt_address, rd_address, rs_address, memwb_rd;
    logic regDest, jump, branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, memwb_RegWrite, flush;
    logic [1:0] ALUOp;
    logic stall_out, zero_out, jump_out, branch_out, MemRead_out, MemtoReg_out, MemWrite_out, RegWrite_out;
    logic [31:0] alu_result_out, store_data_out, branch_target_out;
    logic [4:0] write_reg_out;
    int tests = 0, fails = 0;

    ex_mem_stage dut (
        .clk(clk), .reset(reset), .alu_data(alu_data), .rs(rs), .rt(rt),
        .sign_extend_inp(sign_extend_inp), .rt_address(rt_address), .rd_address(rd_address),
        .regDest(regDest), .jump(jump), .branch(branch), .MemRead(MemRead), .MemtoReg(MemtoReg),
        .MemWrite(MemWrite), .ALUSrc(ALUSrc), .RegWrite(RegWrite), .ALUOp(ALUOp),
        .rs_address(rs_address), .memwb_RegWrite(memwb_RegWrite), .memwb_rd(memwb_rd),
        .memwb_data(memwb_data), .flush(flush), .stall_out(stall_out),
        .alu_result_out(alu_result_out), .store_data_out(store_data_out),
        .write_reg_out(write_reg_out), .branch_target_out(branch_target_out), .zero_out(zero_out),
        .jump_out(jump_out), .branch_out(branch_out), .MemRead_out(MemRead_out),
        .MemtoReg_out(MemtoReg_out), .MemWrite_out(MemWrite_out), .RegWrite_out(RegWrite_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic        src;
        logic [31:0] imm, a, b;
        logic        rdst;
        logic [4:0]  rd;
        logic        br, rw;
        logic [31:0] res;
        logic        z, erw;
        logic [4:0]  ewr;
        logic [31:0] bt;
    } vec_t;
    vec_t tv[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        alu_data = 32'd100; rs = '0; rt = '0; sign_extend_inp = '0;
        rt_address = '0; rd_address = '0; rs_address = '0;
        regDest = 0; jump = 0; branch = 0; MemRead = 0; MemtoReg = 0; MemWrite = 0;
        ALUSrc = 0; RegWrite = 0; ALUOp = 2'b00;
        memwb_RegWrite = 0; memwb_rd = '0; memwb_data = '0; flush = 0;
    endtask

    task automatic setop(input logic [1:0] op, input logic src, input logic [31:0] imm,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] ra,
                         input logic [4:0] rb, input logic rdst, input logic [4:0] rd,
                         input logic br, input logic rw);
        ALUOp = op; ALUSrc = src; sign_extend_inp = imm; rs = a; rt = b;
        rs_address = ra; rt_address = rb; regDest = rdst; rd_address = rd;
        branch = br; RegWrite = rw;
    endtask

    task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp);
        int n, bad;
        n = 0; bad = 0;
        setop(2'b10, 0, 32'h18, a, b, 0, 0, 1, rd, 0, 1);
        MemWrite = 1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!stall_out) break;
            n++;
            if (n > 1 && (RegWrite_out || MemWrite_out)) bad++;
            @(posedge clk);
        end
        @(posedge clk);
        #1;
        chk("mul_stall_cycles", n, 33);
        chk("mul_bubbles", bad, 0);
        chk("mul_result", alu_result_out, exp);
        chk("mul_regwrite", RegWrite_out, 1);
        chk("mul_memwrite", MemWrite_out, 1);
        chk("mul_write_reg", write_reg_out, rd);
        nop();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tv[0]  = '{2'b10, 0, 32'h20, 32'd5, 32'd7, 1, 5'd3, 0, 1, 32'd12, 0, 1, 5'd3, 32'd228};
        tv[1]  = '{2'b10, 0, 32'h22, 32'd0, 32'd1, 1, 5'd4, 0, 1, 32'hFFFFFFFF, 0, 1, 5'd4, 32'd236};
        tv[2]  = '{2'b10, 0, 32'h2A, 32'hFFFFFFFF, 32'd1, 1, 5'd5, 0, 1, 32'd1, 0, 1, 5'd5, 32'd268};
        tv[3]  = '{2'b10, 0, 32'h2A, 32'd1, 32'hFFFFFFFF, 1, 5'd6, 0, 1, 32'd0, 1, 1, 5'd6, 32'd268};
        tv[4]  = '{2'b10, 0, 32'h24, 32'hF0F0, 32'hFF00, 1, 5'd7, 0, 1, 32'hF000, 0, 1, 5'd7, 32'd244};
        tv[5]  = '{2'b10, 0, 32'h25, 32'h0F0F, 32'hF000, 1, 5'd8, 0, 1, 32'hFF0F, 0, 1, 5'd8, 32'd248};
        tv[6]  = '{2'b01, 0, 32'd4, 32'd5, 32'd5, 0, 5'd0, 1, 0, 32'd0, 1, 0, 5'd0, 32'd116};
        tv[7]  = '{2'b00, 1, 32'd8, 32'd10, 32'd0, 0, 5'd0, 0, 1, 32'd18, 0, 1, 5'd0, 32'd132};
        tv[8]  = '{2'b10, 0, 32'h3F, 32'd5, 32'd7, 1, 5'd9, 0, 1, 32'd0, 1, 0, 5'd9, 32'd352};
        tv[9]  = '{2'b10, 0, 32'h20, 32'hFFFFFFFF, 32'd2, 1, 5'd10, 0, 1, 32'd1, 0, 1, 5'd10, 32'd228};
        tv[10] = '{2'b11, 0, 32'h10, 32'd3, 32'd4, 1, 5'd11, 0, 1, 32'd7, 0, 1, 5'd11, 32'd164};
        tv[11] = '{2'b01, 0, 32'hFFFFFFFF, 32'd9, 32'd9, 0, 5'd0, 1, 0, 32'd0, 1, 0, 5'd0, 32'd96};

        nop();
        reset = 1;
        setop(2'b10, 0, 32'h20, 32'd5, 32'd7, 0, 0, 1, 5'd3, 1, 1);
        step();
        step();
        chk("reset_result", alu_result_out, 0);
        chk("reset_regwrite", RegWrite_out, 0);
        chk("reset_branch", branch_out, 0);
        chk("reset_target", branch_target_out, 0);
        chk("reset_write_reg", write_reg_out, 0);
        chk("reset_stall", stall_out, 0);
        reset = 0;
        nop();
        step();

        for (int i = 0; i < 12; i++) begin
            nop();
            setop(tv[i].op, tv[i].src, tv[i].imm, tv[i].a, tv[i].b, 0, 0, tv[i].rdst, tv[i].rd,
                  tv[i].br, tv[i].rw);
            step();
            chk($sformatf("v%0d_result", i), alu_result_out, tv[i].res);
            chk($sformatf("v%0d_zero", i), zero_out, tv[i].z);
            chk($sformatf("v%0d_regwrite", i), RegWrite_out, tv[i].erw);
            chk($sformatf("v%0d_write_reg", i), write_reg_out, tv[i].ewr);
            chk($sformatf("v%0d_target", i), branch_target_out, tv[i].bt);
            chk($sformatf("v%0d_store", i), store_data_out, tv[i].b);
            chk($sformatf("v%0d_branch", i), branch_out, tv[i].br);
        end

        nop();
        setop(2'b10, 0, 32'h20, 32'd5, 32'd7, 5'd1, 5'd2, 1, 5'd3, 0, 1);
        step();
        chk("fwd_first", alu_result_out, 12);
        setop(2'b10, 0, 32'h20, 32'd0, 32'd0, 5'd3, 5'd3, 1, 5'd4, 0, 1);
        memwb_RegWrite = 1; memwb_rd = 5'd3; memwb_data = 32'd99;
        step();
        chk("fwd_exmem_priority", alu_result_out, 24);
        chk("fwd_store", store_data_out, 12);
        setop(2'b10, 0, 32'h20, 32'd0, 32'd0, 5'd5, 5'd5, 1, 5'd6, 0, 1);
        memwb_rd = 5'd5;
        step();
        chk("fwd_memwb", alu_result_out, 198);
        chk("fwd_memwb_store", store_data_out, 99);
        nop();
        step();

        do_mul(32'd7, 32'd6, 5'd12, 32'd42);
        step();
        do_mul(32'hFFFFFFFF, 32'd2, 5'd13, 32'hFFFFFFFE);
        step();

        setop(2'b10, 0, 32'h18, 32'd7, 32'd6, 0, 0, 1, 5'd14, 0, 1);
        step();
        repeat (9) step();
        flush = 1;
        @(negedge clk);
        chk("flush_stall_drop", stall_out, 0);
        step();
        chk("flush_bubble", RegWrite_out, 0);
        nop();
        setop(2'b10, 0, 32'h20, 32'd2, 32'd3, 0, 0, 1, 5'd15, 0, 1);
        @(negedge clk);
        chk("flush_idle", stall_out, 0);
        step();
        chk("flush_next_add", alu_result_out, 5);
        chk("flush_next_rw", RegWrite_out, 1);

        nop();
        setop(2'b10, 0, 32'h18, 32'd7, 32'd6, 0, 0, 1, 5'd16, 0, 1);
        repeat (6) step();
        reset = 1;
        @(negedge clk);
        chk("rst_mul_stall", stall_out, 0);
        step();
        chk("rst_mul_result", alu_result_out, 0);
        chk("rst_mul_rw", RegWrite_out, 0);
        chk("rst_mul_wr", write_reg_out, 0);
        reset = 0;
        nop();
        setop(2'b10, 0, 32'h20, 32'd2, 32'd3, 0, 0, 1, 5'd17, 0, 1);
        @(negedge clk);
        chk("rst_after_stall", stall_out, 0);
        step();
        chk("rst_after_add", alu_result_out, 5);
        chk("rst_after_wr", write_reg_out, 17);
        chk("rst_after_rw", RegWrite_out, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
